// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcode and FSM state
// encodings, plus the bit positions of the {N,Z,C,V} flags.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MULT = 4'd2,
        OP_DIV  = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_NOT  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle of the sequential ALU: a valid/ready request
// channel carrying operands and opcode, and a valid/ready result channel.
interface alu_seq_unit_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, result_hi, flags
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, result_hi, flags
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative engine shared by MULT (right-shifting shift-add) and DIV
// (restoring division); one step per cycle, N steps per operation.
module muldiv_iter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_op,     // 0 = multiply, 1 = divide
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_done,
    output logic [N-1:0] o_lo,
    output logic [N-1:0] o_hi
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          r_busy;
    logic          r_div;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_acc;   // product high half / partial remainder
    logic [N-1:0]  r_q;     // multiplier shifting out / quotient shifting in
    logic [N-1:0]  r_b;

    logic [N:0]    w_sum;
    logic [N:0]    w_shift;
    logic [N:0]    w_diff;
    logic [N-1:0]  w_acc_nx;
    logic [N-1:0]  w_q_nx;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        w_sum    = {1'b0, r_acc} + {1'b0, r_b};
        w_shift  = {r_acc, r_q[N-1]};
        w_diff   = w_shift - {1'b0, r_b};
        if (r_div) begin
            // Bit N of the difference is the borrow: set means the divisor did not fit.
            if (!w_diff[N]) begin
                w_acc_nx = w_diff[N-1:0];
                w_q_nx   = {r_q[N-2:0], 1'b1};
            end else begin
                w_acc_nx = w_shift[N-1:0];
                w_q_nx   = {r_q[N-2:0], 1'b0};
            end
        end else if (r_q[0]) begin
            {w_acc_nx, w_q_nx} = {w_sum, r_q[N-1:1]};
        end else begin
            {w_acc_nx, w_q_nx} = {1'b0, r_acc, r_q[N-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_b    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_busy <= 1'b1;
                r_div  <= i_op;
                r_cnt  <= '0;
                r_acc  <= '0;
                r_q    <= i_a;
                r_b    <= i_b;
            end else if (r_busy) begin
                r_acc <= w_acc_nx;
                r_q   <= w_q_nx;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_lo   = r_q;
    assign o_hi   = r_acc;

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU: single-cycle ops land in the output register on the accept
// edge; MULT and DIV are handed to muldiv_iter and retire N+1 cycles later.
module alu_seq_unit
    import alu_seq_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_unit_if.slave     bus
);
    localparam int SHW = $clog2(N);

    state_t       r_state;
    logic         r_out_valid;
    logic [N-1:0] r_result;
    logic [N-1:0] r_result_hi;
    logic [3:0]   r_flags;

    alu_op_t      w_op;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_multi;
    logic         w_wr;
    logic [N:0]   w_sum;
    logic [N:0]   w_diff;
    logic         w_big_shift;
    logic [N-1:0] w_lo;
    logic [N-1:0] w_hi;
    logic         w_c;
    logic         w_v;
    logic [N-1:0] w_wr_lo;
    logic [N-1:0] w_wr_hi;
    logic [3:0]   w_wr_flags;
    logic         w_md_done;
    logic [N-1:0] w_md_lo;
    logic [N-1:0] w_md_hi;

    assign w_op        = alu_op_t'(bus.alu_control);
    assign w_in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_big_shift = |bus.b[N-1:SHW];

    always_comb begin
        w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
        w_lo    = '0;
        w_hi    = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_multi = 1'b0;
        case (w_op)
            OP_SUB: begin
                w_lo = w_diff[N-1:0];
                w_c  = !w_diff[N];
                w_v  = (bus.a[N-1] != bus.b[N-1]) && (w_diff[N-1] != bus.a[N-1]);
            end
            OP_MULT: w_multi = 1'b1;
            OP_DIV: begin
                if (bus.b == '0) begin
                    w_lo = '1;
                    w_hi = bus.a;
                    w_v  = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
            OP_SLL:  w_lo = w_big_shift ? '0 : bus.a << bus.b[SHW-1:0];
            OP_SRL:  w_lo = w_big_shift ? '0 : bus.a >> bus.b[SHW-1:0];
            OP_AND:  w_lo = bus.a & bus.b;
            OP_OR:   w_lo = bus.a | bus.b;
            OP_XOR:  w_lo = bus.a ^ bus.b;
            OP_NOT:  w_lo = ~bus.a;
            default: begin
                // OP_ADD and the unused encodings 10-15.
                w_lo = w_sum[N-1:0];
                w_c  = w_sum[N];
                w_v  = (bus.a[N-1] == bus.b[N-1]) && (w_sum[N-1] != bus.a[N-1]);
            end
        endcase
    end

    muldiv_iter #(.N(N)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept && w_multi),
        .i_op    (w_op == OP_DIV),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_done  (w_md_done),
        .o_lo    (w_md_lo),
        .o_hi    (w_md_hi)
    );

    // Outside IDLE the only writer is the iterative engine finishing.
    always_comb begin
        w_wr_flags = '0;
        if (r_state != IDLE) begin
            w_wr    = w_md_done;
            w_wr_lo = w_md_lo;
            w_wr_hi = w_md_hi;
            w_wr_flags[FLAG_C] = (r_state == MUL) && (w_md_hi != '0);
        end else begin
            w_wr    = w_accept && !w_multi;
            w_wr_lo = w_lo;
            w_wr_hi = w_hi;
            w_wr_flags[FLAG_C] = w_c;
            w_wr_flags[FLAG_V] = w_v;
        end
        w_wr_flags[FLAG_N] = w_wr_lo[N-1];
        w_wr_flags[FLAG_Z] = (w_wr_lo == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                IDLE:     if (w_accept && w_multi) r_state <= (w_op == OP_MULT) ? MUL : DIV;
                MUL, DIV: if (w_md_done) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
            // A new write wins over consumption so single-cycle ops stream.
            if (w_wr) begin
                r_out_valid <= 1'b1;
                r_result    <= w_wr_lo;
                r_result_hi <= w_wr_hi;
                r_flags     <= w_wr_flags;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at N=8: one task per scenario, expected
// values worked out by hand; flags are written {N,Z,C,V}.
module tb_alu_seq_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_seq_unit_if #(.N(8)) bus ();

    alu_seq_unit #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    // Presents one request and returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        bus.alu_control = op;
        bus.a           = a;
        bus.b           = b;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL accept op=%0d: in_ready never seen high within 20 cycles", op);
        end
    endtask

    // Counts edges after the accept edge until out_valid rises (-1 on timeout).
    task automatic wait_out(output int cyc, output bit ready_seen);
        cyc        = -1;
        ready_seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (bus.in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            if (bus.out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_control = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.flags} !== {1'b0, 1'b1, 8'h00, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset: out_valid=%b in_ready=%b result=%h hi=%h flags=%b, required 0 1 00 00 0000",
                     bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.flags);
        end
    endtask

    task automatic test_add_sub();
        idle_cycle();
        issue(4'd0, 8'd200, 8'd100);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'h2C, 4'b0010}) begin
            n_fail++;
            $display("FAIL add 200+100: valid=%b result=%h flags=%b, required 1 2c 0010",
                     bus.out_valid, bus.result, bus.flags);
        end
        issue(4'd1, 8'd5, 8'd7);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'hFE, 4'b1000}) begin
            n_fail++;
            $display("FAIL sub 5-7: valid=%b result=%h flags=%b, required 1 fe 1000",
                     bus.out_valid, bus.result, bus.flags);
        end
        issue(4'd1, 8'h80, 8'h01);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'h7F, 4'b0011}) begin
            n_fail++;
            $display("FAIL sub 80-1: valid=%b result=%h flags=%b, required 1 7f 0011",
                     bus.out_valid, bus.result, bus.flags);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL consume: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        idle_cycle();
        issue(4'd8, 8'hAA, 8'h0F);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'hA5, 4'b1000}) begin
            n_fail++;
            $display("FAIL xor: valid=%b result=%h flags=%b, required 1 a5 1000", bus.out_valid, bus.result, bus.flags);
        end
        issue(4'd7, 8'h00, 8'h00);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'h00, 4'b0100}) begin
            n_fail++;
            $display("FAIL or zero: valid=%b result=%h flags=%b, required 1 00 0100", bus.out_valid, bus.result, bus.flags);
        end
        issue(4'd9, 8'h0F, 8'h55);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'hF0, 4'b1000}) begin
            n_fail++;
            $display("FAIL not: valid=%b result=%h flags=%b, required 1 f0 1000", bus.out_valid, bus.result, bus.flags);
        end
        issue(4'd12, 8'h01, 8'h02);
        n_checks++;
        if ({bus.result, bus.flags} !== {8'h03, 4'b0000}) begin
            n_fail++;
            $display("FAIL opcode12 as add: result=%h flags=%b, required 03 0000", bus.result, bus.flags);
        end
    endtask

    task automatic test_shift();
        idle_cycle();
        issue(4'd5, 8'h80, 8'd7);
        n_checks++;
        if ({bus.result, bus.flags} !== {8'h01, 4'b0000}) begin
            n_fail++;
            $display("FAIL srl 80>>7: result=%h flags=%b, required 01 0000", bus.result, bus.flags);
        end
        issue(4'd4, 8'hFF, 8'd8);
        n_checks++;
        if ({bus.result, bus.flags} !== {8'h00, 4'b0100}) begin
            n_fail++;
            $display("FAIL sll by 8: result=%h flags=%b, required 00 0100", bus.result, bus.flags);
        end
        issue(4'd4, 8'h81, 8'd1);
        n_checks++;
        if ({bus.result, bus.flags} !== {8'h02, 4'b0000}) begin
            n_fail++;
            $display("FAIL sll 81<<1: result=%h flags=%b, required 02 0000", bus.result, bus.flags);
        end
    endtask

    task automatic test_mult();
        int cyc;
        bit rdy;
        idle_cycle();
        issue(4'd2, 8'd16, 8'd16);
        wait_out(cyc, rdy);
        n_checks++;
        if (cyc !== 9 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL mult latency: cycles=%0d in_ready_seen=%b, required 9 0", cyc, rdy);
        end
        n_checks++;
        if ({bus.result, bus.result_hi, bus.flags} !== {8'h00, 8'h01, 4'b0110}) begin
            n_fail++;
            $display("FAIL mult 16*16: result=%h hi=%h flags=%b, required 00 01 0110",
                     bus.result, bus.result_hi, bus.flags);
        end
        issue(4'd2, 8'd15, 8'd17);
        wait_out(cyc, rdy);
        n_checks++;
        if ({bus.result, bus.result_hi, bus.flags} !== {8'hFF, 8'h00, 4'b1000} || cyc !== 9) begin
            n_fail++;
            $display("FAIL mult 15*17: result=%h hi=%h flags=%b cycles=%0d, required ff 00 1000 9",
                     bus.result, bus.result_hi, bus.flags, cyc);
        end
    endtask

    task automatic test_div();
        int cyc;
        bit rdy;
        idle_cycle();
        issue(4'd3, 8'd100, 8'd7);
        wait_out(cyc, rdy);
        n_checks++;
        if (cyc !== 9 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL div latency: cycles=%0d in_ready_seen=%b, required 9 0", cyc, rdy);
        end
        n_checks++;
        if ({bus.result, bus.result_hi, bus.flags} !== {8'd14, 8'd2, 4'b0000}) begin
            n_fail++;
            $display("FAIL div 100/7: result=%0d hi=%0d flags=%b, required 14 2 0000",
                     bus.result, bus.result_hi, bus.flags);
        end
        issue(4'd3, 8'd42, 8'd0);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.result_hi, bus.flags} !== {1'b1, 8'hFF, 8'd42, 4'b1001}) begin
            n_fail++;
            $display("FAIL div 42/0: valid=%b result=%h hi=%0d flags=%b, required 1 ff 42 1001",
                     bus.out_valid, bus.result, bus.result_hi, bus.flags);
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        bit rdy;
        idle_cycle();
        bus.out_ready = 1'b0;
        issue(4'd0, 8'd3, 8'd4);
        n_checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, 8'h07}) begin
            n_fail++;
            $display("FAIL bp add: valid=%b result=%h, required 1 07", bus.out_valid, bus.result);
        end
        bus.alu_control = 4'd6;
        bus.a           = 8'hF0;
        bus.b           = 8'h3C;
        bus.in_valid    = 1'b1;
        stable = 1'b1;
        rdy    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.in_ready) rdy = 1'b1;
            if ({bus.out_valid, bus.result, bus.result_hi, bus.flags} !== {1'b1, 8'h07, 8'h00, 4'b0000})
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp hold: stable=%b in_ready_seen=%b, required 1 0", stable, rdy);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'h30, 4'b0000}) begin
            n_fail++;
            $display("FAIL bp and release: valid=%b result=%h flags=%b, required 1 30 0000",
                     bus.out_valid, bus.result, bus.flags);
        end
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        idle_cycle();
        idle_cycle();
        issue(4'd3, 8'd100, 8'd7);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.flags} !== {1'b0, 1'b1, 8'h00, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset mid div: out_valid=%b in_ready=%b result=%h hi=%h flags=%b, required 0 1 00 00 0000",
                     bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.flags);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL aborted div: out_valid rose after reset, required none");
        end
        issue(4'd4, 8'h01, 8'd3);
        n_checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 8'h08, 4'b0000}) begin
            n_fail++;
            $display("FAIL sll after reset: valid=%b result=%h flags=%b, required 1 08 0000",
                     bus.out_valid, bus.result, bus.flags);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_add_sub();
        test_back_to_back();
        test_shift();
        test_mult();
        test_div();
        test_backpressure();
        test_reset_mid_div();
        idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the ARMv4 combinational ALU result mux. It executes ten operations on N-bit operands. ADD/SUB/logic/shift ops retire in one cycle; MULT and DIV run iteratively over N cycles. Results and NZCV flags are held in an output register behind a valid/ready handshake, so the datapath can stall on a multi-cycle op or on downstream back-pressure.

## Interface
- N, 32, operand/result width (≥4, power of two)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept request this cycle
- a, b  in  N  operands (unsigned for MULT/DIV)
- alu_control  in  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT(a); 10–15 decode as ADD
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result
- result  out  N  primary result (MULT low half, DIV quotient)
- result_hi  out  N  MULT high half, DIV remainder, else 0
- flags  out  4  {N,Z,C,V}

## Operation
- Accept when in_valid && in_ready; operands and opcode are captured on that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Single-cycle ops produce the result in the output register on the accept edge.
  - SLL/SRL are logical shifts by the full b; b ≥ N gives 0.
- MULT: shift-add over N iterations, producing a 2N-bit product.
- DIV: restoring division over N iterations.
  - b==0 takes the single-cycle path: result all-ones, result_hi=a, V=1.
- Flags:
  - N = result[N-1]; Z = (result==0).
  - ADD: C = carry-out, V = signed overflow.
  - SUB: C = no-borrow (a≥b unsigned), V = signed overflow.
  - MULT: C = (result_hi≠0), V=0.
  - DIV: C=0, V = divide-by-zero.
  - Logic/shift: C=V=0.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL/DIV on accept of opcode 2/3 (b≠0 for DIV).
  - MUL/DIV→IDLE when the iteration counter reaches N-1, writing the output register and setting out_valid.
  - Counter width is $clog2(N) and is cleared on entry.
- out_valid clears on out_valid && out_ready unless a new result is written on the same edge. Write takes priority, so back-to-back single-cycle ops stream at one per cycle.
- While out_valid && !out_ready, result/result_hi/flags are held stable.

## Timing
- Reset (rst_n low at an edge): state=IDLE, counter=0, out_valid=0, result=result_hi=0, flags=0. in_ready is high from the first cycle after reset.
- Reset mid-MULT/DIV aborts the op; no result is produced.
- Single-cycle op latency: out_valid high in the cycle after accept.
- MULT/DIV (b≠0) latency: out_valid high N+1 cycles after accept.
- in_ready is low throughout MUL/DIV and while the output is held un-consumed.
- in_valid without in_ready has no effect; the requester must hold a/b/alu_control stable until accepted.

## Structure
- Package alu_seq_pkg:
  - alu_op_t enum (ADD..NOT, 4-bit)
  - state_t enum (IDLE, MUL, DIV)
  - flag index constants FLAG_N/Z/C/V
- Sub-module muldiv_iter (parameter N) holds the shared shift register, accumulator and counter for MULT/DIV.
  - Interface: start, op, a, b, done, lo, hi.
  - The top level keeps the FSM, single-cycle datapath, flag logic and output register.

## Test plan
- N=8, ADD a=200 b=100 -> next cycle result=0x2C, flags N0 Z0 C1 V0.
- SUB a=5 b=7 -> result=0xFE, N1 Z0 C0 V0. Then SUB a=0x80 b=1 -> result=0x7F, V1 C1.
- MULT 16×16 -> out_valid after 9 cycles, result=0x00, result_hi=0x01, Z1 C1. MULT 15×17 -> result=0xFF, result_hi=0, C0.
- DIV 100/7 -> out_valid after 9 cycles, result=14, result_hi=2. DIV 42/0 -> next cycle result=0xFF, result_hi=42, V1.
- Back-pressure: hold out_ready=0 after an ADD; in_ready stays 0 and the result stays stable for 5 cycles. Raising out_ready with a queued AND 0xF0&0x3C yields result=0x30 on the following cycle.
- Assert rst_n=0 for one edge at cycle 4 of a DIV: out_valid=0, all outputs 0, in_ready=1 next cycle. A subsequent SLL 0x01<<3 gives 0x08.
